// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   CPU_WIDTH        data/address width
//   MEM_SIZE_*       access size encodings (2'b11 behaves as a word)
//   dma_state_e      arbiter FSM state encodings
//   is_misaligned()  alignment rule shared by the arbiter
package dmem_arbiter_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    DMA_IDLE     = 2'd0,
    DMA_ACCESS   = 2'd1,
    DMA_MERGE_WR = 2'd2,
    DMA_RESP     = 2'd3
  } dma_state_e;

  // Bytes are always aligned; halves need addr[0]=0; words (and size 11) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = addr_lo[0];
      default:    mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-lane steering between a memory word and a right-aligned requester value.
//   word_i     word read from the data memory
//   addr_lo_i  byte offset within the word
//   size_i     access size (byte / half / word)
//   wdata_i    right-aligned store data
//   load_o     selected lane, right-aligned and zero-extended
//   merged_o   word_i with the addressed lane(s) replaced by wdata_i
module dmem_lane_mux
  import dmem_arbiter_pkg::*;
(
  input  logic [CPU_WIDTH-1:0] word_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [1:0]           size_i,
  input  logic [CPU_WIDTH-1:0] wdata_i,
  output logic [CPU_WIDTH-1:0] load_o,
  output logic [CPU_WIDTH-1:0] merged_o
);

  logic [4:0]           shamt;
  logic [CPU_WIDTH-1:0] lane_mask;

  always_comb begin
    shamt     = 5'd0;
    lane_mask = '1;
    case (size_i)
      MEM_SIZE_B: begin
        shamt     = {addr_lo_i, 3'b000};
        lane_mask = 32'h0000_00FF;
      end
      MEM_SIZE_H: begin
        // Only called with aligned halves, so addr_lo_i[0] is zero here.
        shamt     = {addr_lo_i[1], 4'b0000};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        shamt     = 5'd0;
        lane_mask = '1;
      end
    endcase
  end

  assign load_o   = (word_i >> shamt) & lane_mask;
  assign merged_o = (word_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port, word-wide data memory.
// Byte/half stores become read-modify-write because the memory only writes full words.
//   clk, rstn                 clock, async active-low reset
//   mN_req/we/size/addr/wdata requester N (0 = core LSU, 1 = debug/DMA) request side
//   mN_gnt                    1-cycle accept pulse (combinational in IDLE)
//   mN_rvalid/rdata/err       1-cycle completion with zero-extended load data / misalign flag
//   mem_addr/wdata/write_en/read_en, mem_rdata   data memory (combinational read)
//
// state        | meaning
// DMA_IDLE     | no access in flight; arbitrate, grant, latch the request
// DMA_ACCESS   | read addressed word; finish load / word store, or build merged word
// DMA_MERGE_WR | write the merged word of a byte/half store
// DMA_RESP     | pulse owner's rvalid with rdata/err; advance round-robin pointer
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [1:0]           m0_size,
  input  logic [CPU_WIDTH-1:0] m0_addr,
  input  logic [CPU_WIDTH-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [CPU_WIDTH-1:0] m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [1:0]           m1_size,
  input  logic [CPU_WIDTH-1:0] m1_addr,
  input  logic [CPU_WIDTH-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [CPU_WIDTH-1:0] m1_rdata,
  output logic                 m1_err,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  input  logic [CPU_WIDTH-1:0] mem_rdata
);

  dma_state_e           state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;   // 0 = m0 preferred on a tie
  logic                 owner_q, owner_d;     // 0 = m0, 1 = m1
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
  logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CPU_WIDTH-1:0] merged_q, merged_d;

  logic                 pick_m1;
  logic [CPU_WIDTH-1:0] lane_load;
  logic [CPU_WIDTH-1:0] lane_merged;
  logic [CPU_WIDTH-1:0] word_addr;

  // m1 wins when it is alone, or on a tie when round-robin points at it.
  assign pick_m1   = m1_req && (!m0_req || (RR_EN && rr_ptr_q));
  assign word_addr = {addr_q[CPU_WIDTH-1:2], 2'b00};

  dmem_lane_mux u_lane_mux (
    .word_i    (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .load_o    (lane_load),
    .merged_o  (lane_merged)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    merged_d     = merged_q;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;

    unique case (state_q)
      DMA_IDLE: begin
        // rstn gates the combinational grant so nothing is accepted while reset is held.
        if (rstn && (m0_req || m1_req)) begin
          owner_d = pick_m1;
          m0_gnt  = !pick_m1;
          m1_gnt  = pick_m1;
          we_d    = pick_m1 ? m1_we    : m0_we;
          size_d  = pick_m1 ? m1_size  : m0_size;
          addr_d  = pick_m1 ? m1_addr  : m0_addr;
          wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          rdata_d = '0;
          if (is_misaligned(size_d, addr_d[1:0])) begin
            err_d   = 1'b1;
            state_d = DMA_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = DMA_ACCESS;
          end
        end
      end

      DMA_ACCESS: begin
        mem_addr    = word_addr;
        mem_read_en = 1'b1;
        if (!we_q) begin
          rdata_d = lane_load;
          state_d = DMA_RESP;
        end else if (size_q[1]) begin
          mem_write_en = 1'b1;
          mem_wdata    = wdata_q;
          state_d      = DMA_RESP;
        end else begin
          merged_d = lane_merged;
          state_d  = DMA_MERGE_WR;
        end
      end

      DMA_MERGE_WR: begin
        mem_addr     = word_addr;
        mem_write_en = 1'b1;
        mem_wdata    = merged_q;
        state_d      = DMA_RESP;
      end

      DMA_RESP: begin
        if (owner_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = rdata_q;
          m1_err    = err_q;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = rdata_q;
          m0_err    = err_q;
        end
        if (RR_EN) begin
          rr_ptr_d = !owner_q;
        end
        state_d = DMA_IDLE;
      end

      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= DMA_IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a memory model behind the DUT, a byte-level reference model of
// that memory, and a scoreboard of expected completions pushed at grant time.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write_en, mem_read_en;

  // Second instance, fixed priority, used only for the starvation check.
  logic        fp_m0_req = 0, fp_m1_req = 0;
  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_write_en, fp_mem_read_en;
  logic [31:0] fp_mem_rdata;
  assign fp_mem_rdata = 32'h0;

  dmem_arbiter #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .rstn(rstn),
    .m0_req(fp_m0_req), .m0_we(1'b0), .m0_size(MEM_SIZE_W), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(fp_m1_req), .m1_we(1'b0), .m1_size(MEM_SIZE_W), .m1_addr(32'h4), .m1_wdata(32'h0),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_write_en(fp_mem_write_en),
    .mem_read_en(fp_mem_read_en), .mem_rdata(fp_mem_rdata)
  );

  // 1 KB memory window; preload goes through pl_* so each array has a single writer.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pl_we = 0;
  logic [7:0]  pl_idx = 0;
  logic [31:0] pl_val = 0;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (mem_write_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          nwr;
    logic        rd;
    logic        upd;
    int          idx;
    logic [31:0] nword;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   cyc = 0;
  int   last_resp = -1;
  int   wr_cnt = 0, rd_cnt = 0, rv_cnt = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int p, input logic we, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd, input int t);
    exp_t e;
    int nb, lo;
    logic mis;
    logic [31:0] w;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lo = int'(a[1:0]);
    mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    w = ref_mem[a[9:2]];
    e.port = p; e.rdata = 0; e.err = 0; e.nwr = 0; e.rd = 1; e.upd = 0;
    e.idx = int'(a[9:2]); e.nword = w;
    if (mis) begin
      e.err = 1; e.cyc = t + 1; e.rd = 0;
    end else if (!we) begin
      for (int i = 0; i < nb; i++) e.rdata[8*i +: 8] = w[8*(lo+i) +: 8];
      e.cyc = t + 2;
    end else begin
      for (int i = 0; i < nb; i++) e.nword[8*(lo+i) +: 8] = wd[8*i +: 8];
      e.cyc = (nb == 4) ? t + 2 : t + 3;
      e.nwr = 1; e.upd = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int p;
    if (pl_we) ref_mem[pl_idx] = pl_val;
    if (!rstn) begin
      sb.delete();
    end else begin
      if (mem_write_en) begin
        wr_cnt++;
        if (sb.size() == 0) check("wr_idle", 1, 0);
      end
      if (mem_read_en) rd_cnt++;
      if (m0_rvalid || m1_rvalid) begin
        rv_cnt++;
        if (sb.size() == 0) begin
          check("rv_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          p = e.port;
          check("rv_port", {30'b0, m0_rvalid, m1_rvalid}, (p == 1) ? 32'd1 : 32'd2);
          last_rdata = (p == 1) ? m1_rdata : m0_rdata;
          last_err   = (p == 1) ? m1_err : m0_err;
          check("rv_rdata", last_rdata, e.rdata);
          check("rv_err", last_err, e.err);
          check("rv_latency", cyc, e.cyc);
          check("wr_cnt", wr_cnt, e.nwr);
          check("rd_seen", rd_cnt != 0, e.rd);
          if (e.upd) ref_mem[e.idx] = e.nword;
          last_resp = cyc;
        end
      end
      if (m0_gnt || m1_gnt) begin
        check("gnt_onehot", m0_gnt & m1_gnt, 0);
        check("gnt_gap", cyc > last_resp, 1);
        p = m1_gnt ? 1 : 0;
        gnt_log.push_back(p);
        if (p == 1) sb.push_back(model(1, m1_we, m1_size, m1_addr, m1_wdata, cyc));
        else        sb.push_back(model(0, m0_we, m0_size, m0_addr, m0_wdata, cyc));
        wr_cnt = 0;
        rd_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    pl_idx = a[9:2]; pl_val = v; pl_we = 1;
    @(posedge clk); #1;
    pl_we = 0;
  endtask

  task automatic req_port(input int p, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    bit got;
    got = 0;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_gnt : m1_gnt;
    end
    if (!got) check("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (p == 0) m0_req = 0; else m1_req = 0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !m0_req && !m1_req;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {24'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                          mem_write_en, mem_read_en}, 0);
    check({tag, "_data"}, m0_rdata | m1_rdata | mem_addr | mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, c1, rv0;
    bit got;
    for (int i = 0; i < 256; i++) begin
      preload(32'(i * 4), 32'h0);
    end
    preload(32'h10, 32'h1122_3344);
    preload(32'h10064, 32'hAAAA_AAAA);
    preload(32'h30, 32'hCAFE_F00D);
    // A request during reset must not be granted.
    m0_req = 1; #1;
    check_reset_outs("reset");
    m0_req = 0;
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    // lb from lane 2
    req_port(0, 0, MEM_SIZE_B, 32'h12, 0);
    wait_drain();
    check("t1_lb", last_rdata, 32'h0000_0022);

    // sh into a word of 0xAAAAAAAA, then lh of the other half
    req_port(0, 1, MEM_SIZE_H, 32'h10064, 32'h0000_BEEF);
    wait_drain();
    check("t2_mem", mem[8'h19], 32'hAAAA_BEEF);
    req_port(0, 0, MEM_SIZE_H, 32'h10066, 0);
    wait_drain();
    check("t2_lh", last_rdata, 32'h0000_AAAA);

    // misaligned word load from m1
    req_port(1, 0, MEM_SIZE_W, 32'h10002, 0);
    wait_drain();
    check("t4_err", last_err, 1);

    // more lane patterns: sb lane 3, lb lane 1, size 11 load, misaligned half store
    req_port(1, 1, MEM_SIZE_B, 32'h33, 32'h0000_005A);
    req_port(1, 0, MEM_SIZE_B, 32'h31, 0);
    wait_drain();
    check("mx_lb", last_rdata, 32'h0000_00F0);
    check("mx_mem", mem[8'h0C], 32'h5AFE_F00D);
    req_port(0, 0, 2'b11, 32'h30, 0);
    req_port(0, 1, MEM_SIZE_H, 32'h31, 32'h1234);
    wait_drain();
    check("mx_mem_keep", mem[8'h0C], 32'h5AFE_F00D);

    // back-to-back sw then lw to the same word
    req_port(0, 1, MEM_SIZE_W, 32'h20, 32'hDEAD_BEEF);
    req_port(0, 0, MEM_SIZE_W, 32'h20, 0);
    wait_drain();
    check("t6_lw", last_rdata, 32'hDEAD_BEEF);

    // round-robin alternation from a fresh reset
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1;
    base = gnt_log.size();
    fork
      begin
        req_port(0, 0, MEM_SIZE_B, 32'h10, 0);
        req_port(0, 0, MEM_SIZE_W, 32'h10, 0);
      end
      begin
        req_port(1, 0, MEM_SIZE_H, 32'h12, 0);
        req_port(1, 0, MEM_SIZE_B, 32'h13, 0);
      end
    join
    wait_drain();
    check("t3_ngnt", gnt_log.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < gnt_log.size()) check("t3_order", gnt_log[base+k], k % 2);
    end

    // fixed priority: m1 starved while m0 keeps requesting
    fp_m0_req = 1; fp_m1_req = 1;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      c0 += int'(fp_m0_gnt);
      c1 += int'(fp_m1_gnt);
    end
    check("t3b_m0_gnts", c0, 10);
    check("t3b_m1_gnts", c1, 0);
    @(posedge clk); #1;
    fp_m0_req = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = fp_m1_gnt;
    end
    check("t3b_m1_after", got, 1);
    @(posedge clk); #1;
    fp_m1_req = 0;
    repeat (4) @(posedge clk); #1;

    // reset during MERGE_WR of a byte store; rr_ptr points at m1 beforehand
    req_port(0, 0, MEM_SIZE_W, 32'h10, 0);
    wait_drain();
    req_port(0, 1, MEM_SIZE_B, 32'h11, 32'h0000_0055);
    @(posedge clk); #1;
    check("t5_merge_we", mem_write_en, 1);
    rstn = 0;
    #1;
    check_reset_outs("t5_reset");
    rv0 = rv_cnt;
    repeat (3) @(posedge clk);
    check("t5_mem", mem[8'h04], 32'h1122_3344);
    #1 rstn = 1;
    repeat (3) @(posedge clk);
    check("t5_no_rvalid", rv_cnt, rv0);
    #1;
    base = gnt_log.size();
    fork
      req_port(0, 0, MEM_SIZE_W, 32'h10, 0);
      req_port(1, 0, MEM_SIZE_W, 32'h20, 0);
    join
    wait_drain();
    check("t5_first_gnt", (gnt_log.size() > base) ? gnt_log[base] : -1, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
